// File: rtl/ah_div_pipe_param.sv
// Fully pipelined restoring integer divider: one operation per cycle, signed or unsigned,
// with remainder, divide-by-zero flag, pass-through tag and valid/ready backpressure.
module ah_div_pipe_param #(
  parameter int WIDTH      = 32,
  parameter int STAGE_BITS = 1,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int N = WIDTH / STAGE_BITS;

  // STAGE_BITS restoring shift-subtract steps; the trial value is WIDTH+1 bits so a
  // shifted remainder never overflows before the compare.
  function automatic logic [2*WIDTH-1:0] div_steps(input logic [WIDTH-1:0] rem_in,
                                                   input logic [WIDTH-1:0] quo_in,
                                                   input logic [WIDTH-1:0] dvs);
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH:0]   trial;
    rem = rem_in;
    quo = quo_in;
    for (int i = 0; i < STAGE_BITS; i++) begin
      trial = {rem, quo[WIDTH-1]};
      quo   = {quo[WIDTH-2:0], 1'b0};
      if (trial >= {1'b0, dvs}) begin
        trial  = trial - {1'b0, dvs};
        quo[0] = 1'b1;
      end
      rem = trial[WIDTH-1:0];
    end
    return {rem, quo};
  endfunction

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Index 0 is the operand register; 1..N are the iteration stages.
  logic [N:0]       vld_s;
  logic [N:0]       negq_s;
  logic [N:0]       negr_s;
  logic [N:0]       dbz_s;
  logic [WIDTH-1:0] rem_s [0:N];
  logic [WIDTH-1:0] quo_s [0:N];
  logic [WIDTH-1:0] dvs_s [0:N];
  logic [TAG_W-1:0] tag_s [0:N];

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;

  // The most negative value negates to itself, which is its correct unsigned magnitude.
  assign dvd_neg = in_signed & dividend[WIDTH-1];
  assign dvs_neg = in_signed & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor : divisor;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_s  <= '0;
      negq_s <= '0;
      negr_s <= '0;
      dbz_s  <= '0;
      for (int k = 0; k <= N; k++) begin
        rem_s[k] <= '0;
        quo_s[k] <= '0;
        dvs_s[k] <= '0;
        tag_s[k] <= '0;
      end
    end else if (!stall) begin
      vld_s[0]  <= in_valid;
      negq_s[0] <= dvd_neg ^ dvs_neg;
      negr_s[0] <= dvd_neg;
      dbz_s[0]  <= (divisor == '0);
      rem_s[0]  <= '0;
      quo_s[0]  <= dvd_mag;
      dvs_s[0]  <= dvs_mag;
      tag_s[0]  <= in_tag;
      for (int k = 1; k <= N; k++) begin
        vld_s[k]  <= vld_s[k-1];
        negq_s[k] <= negq_s[k-1];
        negr_s[k] <= negr_s[k-1];
        dbz_s[k]  <= dbz_s[k-1];
        dvs_s[k]  <= dvs_s[k-1];
        tag_s[k]  <= tag_s[k-1];
        {rem_s[k], quo_s[k]} <= div_steps(rem_s[k-1], quo_s[k-1], dvs_s[k-1]);
      end
    end
  end

  // With a zero divisor the iterations leave the dividend magnitude in the remainder,
  // so re-applying the dividend sign restores the original dividend bits.
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  assign q_fix = dbz_s[N] ? '1 : (negq_s[N] ? -quo_s[N] : quo_s[N]);
  assign r_fix = negr_s[N] ? -rem_s[N] : rem_s[N];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      out_tag     <= '0;
    end else if (!stall) begin
      out_valid   <= vld_s[N];
      quotient    <= q_fix;
      remainder   <= r_fix;
      div_by_zero <= dbz_s[N];
      out_tag     <= tag_s[N];
    end
  end

endmodule

// File: tb/tb_ah_div_pipe_param.sv
// Bench for ah_div_pipe_param (WIDTH=8, STAGE_BITS=1): directed vector table, latency,
// backpressure and reset sequences, plus random traffic scored against an arithmetic model.
module tb_ah_div_pipe_param;
  localparam int W  = 8;
  localparam int SB = 1;
  localparam int TW = 4;
  localparam int L  = W / SB + 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_signed = 1'b0;
  logic          out_ready = 1'b1;
  logic [W-1:0]  dividend = '0;
  logic [W-1:0]  divisor = '0;
  logic [TW-1:0] in_tag = '0;
  logic          in_ready;
  logic          out_valid;
  logic          div_by_zero;
  logic [W-1:0]  quotient;
  logic [W-1:0]  remainder;
  logic [TW-1:0] out_tag;

  ah_div_pipe_param #(.WIDTH(W), .STAGE_BITS(SB), .TAG_W(TW)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_signed(in_signed), .dividend(dividend), .divisor(divisor), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, plus the two special cases.
  task automatic model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    int sa;
    int sb;
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1;
    end else if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      dz = 1'b0;
      if (sa == -128 && sb == -1) begin
        q = 8'h80; r = 8'h00;
      end else begin
        q = 8'(sa / sb); r = 8'(sa % sb);
      end
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endtask

  typedef struct {
    logic [W-1:0]  q;
    logic [W-1:0]  r;
    logic          dz;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   pops = 0;
  int   run_len = 0;
  int   max_run = 0;
  logic stall_prev = 1'b0;
  logic [W-1:0]  hold_q, hold_r;
  logic          hold_dz;
  logic [TW-1:0] hold_tag;

  // Scoreboard: push on acceptance, pop on delivery, and hold-stability during stalls.
  always @(negedge clk) begin
    exp_t e;
    logic [W-1:0] mq, mr;
    logic mdz;
    if (!rstn) begin
      exp_q.delete();
      run_len = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_quotient", quotient, hold_q);
        check("hold_remainder", remainder, hold_r);
        check("hold_dbz", div_by_zero, hold_dz);
        check("hold_tag", out_tag, hold_tag);
      end
      if (out_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (out_valid && out_ready) begin
        pops++;
        $display("RESULT tag=%0d q=0x%02h r=0x%02h dbz=%0d", out_tag, quotient, remainder, div_by_zero);
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_quotient", quotient, e.q);
          check("sb_remainder", remainder, e.r);
          check("sb_dbz", div_by_zero, e.dz);
          check("sb_tag", out_tag, e.tag);
        end
      end
      if (in_valid && in_ready) begin
        model(in_signed, dividend, divisor, mq, mr, mdz);
        e.q = mq; e.r = mr; e.dz = mdz; e.tag = in_tag;
        exp_q.push_back(e);
      end
      stall_prev = out_valid && !out_ready;
      hold_q = quotient; hold_r = remainder; hold_dz = div_by_zero; hold_tag = out_tag;
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the op.
  task automatic send(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [TW-1:0] t);
    bit ok = 0;
    in_valid = 1'b1; in_signed = s; dividend = a; divisor = b; in_tag = t;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    check("send_accepted", ok, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h80;
      3: return 8'h01;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic send_rand();
    send(1'($urandom), pick(), pick(), 4'($urandom));
  endtask

  // Sends one op and checks latency and result against constants.
  task automatic single(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] t, input logic [W-1:0] q, input logic [W-1:0] r,
                        input logic dz);
    int lat = 1;
    bit got = 0;
    send(s, a, b, t);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid) begin got = 1; break; end
      @(posedge clk);
      lat++;
    end
    check("vec_seen", got, 1);
    if (got) begin
      check("vec_latency", lat, L);
      check("vec_quotient", quotient, q);
      check("vec_remainder", remainder, r);
      check("vec_dbz", div_by_zero, dz);
      check("vec_tag", out_tag, t);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input int expect_pops, input int pops0);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check("drain_empty", exp_q.size(), 0);
    check("drain_count", pops - pops0, expect_pops);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic          s;
    logic [W-1:0]  a, b;
    logic [TW-1:0] t;
    logic [W-1:0]  q, r;
    logic          dz;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #600000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops0;
    vecs[0]  = '{1'b0, 8'd200, 8'd7,  4'd3,  8'd28,  8'd4,  1'b0};
    vecs[1]  = '{1'b1, 8'hF9,  8'h02, 4'd5,  8'hFD,  8'hFF, 1'b0};
    vecs[2]  = '{1'b1, 8'h07,  8'hFE, 4'd6,  8'hFD,  8'h01, 1'b0};
    vecs[3]  = '{1'b1, 8'h80,  8'hFF, 4'd7,  8'h80,  8'h00, 1'b0};
    vecs[4]  = '{1'b0, 8'd13,  8'h00, 4'd8,  8'hFF,  8'd13, 1'b1};
    vecs[5]  = '{1'b1, 8'hF3,  8'h00, 4'd9,  8'hFF,  8'hF3, 1'b1};
    vecs[6]  = '{1'b1, 8'h80,  8'h01, 4'd10, 8'h80,  8'h00, 1'b0};
    vecs[7]  = '{1'b0, 8'hFF,  8'h01, 4'd11, 8'hFF,  8'h00, 1'b0};
    vecs[8]  = '{1'b0, 8'h07,  8'hC8, 4'd12, 8'h00,  8'h07, 1'b0};
    vecs[9]  = '{1'b1, 8'h80,  8'h02, 4'd13, 8'hC0,  8'h00, 1'b0};
    vecs[10] = '{1'b0, 8'h80,  8'hFF, 4'd14, 8'h00,  8'h80, 1'b0};

    // Reset state
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_tag", out_tag, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++)
      single(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].t, vecs[i].q, vecs[i].r, vecs[i].dz);

    // 16 back-to-back random ops must come out as 16 consecutive valid cycles
    pops0 = pops;
    max_run = 0;
    for (int i = 0; i < 16; i++) send_rand();
    drain(16, pops0);
    check("burst_consecutive", max_run, 16);

    // Five ops, then 3 cycles of backpressure after the first result
    pops0 = pops;
    fork
      begin
        for (int i = 0; i < 5; i++) send_rand();
      end
      begin
        bit seen = 0;
        for (int c = 0; c < 40; c++) begin
          @(negedge clk);
          if (out_valid) begin seen = 1; break; end
        end
        check("stall_first_seen", seen, 1);
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain(5, pops0);

    // Reset with four ops in flight: none of them may surface
    for (int i = 0; i < 4; i++) send_rand();
    rstn = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1 rstn = 1'b1;
    for (int c = 0; c < L; c++) begin
      @(negedge clk);
      check("post_rst_quiet", out_valid, 0);
    end
    @(posedge clk); #1;
    single(1'b1, 8'h9C, 8'h07, 4'd6, 8'hF2, 8'hFE, 1'b0);

    // Random traffic with random gaps and random backpressure
    pops0 = pops;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send_rand();
        end
      end
      begin
        for (int c = 0; c < 120; c++) begin
          @(posedge clk); #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain(40, pops0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
